// File: rtl/mem_bist_pkg.sv
// Shared state encoding, read-latency constants and data pattern for the memory BIST sequencer.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone,
    StWriteInv,
    StReadInv,
    StDrainInv
  } bist_state_e;

  localparam int unsigned RdLatComb = 0;
  localparam int unsigned RdLatReg  = 1;

  // Callers truncate the result to their data width.
  function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] offset,
                                      input logic inv);
    logic [31:0] sum;
    sum = addr + offset;
    return inv ? ~sum : sum;
  endfunction

endpackage

// File: rtl/bist_cmp_pipe.sv
// Read-data pipeline, comparator, saturating error counter and first-failure capture.
module bist_cmp_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned RD_LAT     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  vld_i,
  input  logic [ADDR_BITS-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic [ADDR_BITS:0]    err_count_o,
  output logic [ADDR_BITS-1:0]  first_fail_addr_o
);
  import mem_bist_pkg::*;

  logic                  vld_p;
  logic [ADDR_BITS-1:0]  addr_p;
  logic [DATA_WIDTH-1:0] exp_p;
  logic [ADDR_BITS:0]    err_count_q;
  logic [ADDR_BITS-1:0]  first_fail_addr_q;
  logic                  mismatch;

  if (RD_LAT == RdLatReg) begin : g_pipe
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_p  <= 1'b0;
        addr_p <= '0;
        exp_p  <= '0;
      end else begin
        vld_p  <= vld_i;
        addr_p <= addr_i;
        exp_p  <= exp_i;
      end
    end
  end else begin : g_comb
    assign vld_p  = vld_i;
    assign addr_p = addr_i;
    assign exp_p  = exp_i;
  end

  assign mismatch = vld_p && (dout_i != exp_p);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      err_count_q       <= '0;
      first_fail_addr_q <= '0;
    end else if (mismatch) begin
      if (err_count_q == '0) first_fail_addr_q <= addr_p;
      if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
    end
  end

  assign err_count_o       = err_count_q;
  assign first_fail_addr_o = first_fail_addr_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Write-then-read-back BIST sequencer for reg_mem; all memory-side outputs are registered.
// Defining MEM_BIST_INV_PASS_EN adds a second sweep with the inverted pattern.
module mem_bist_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned OFFSET     = 0,
  parameter int unsigned RD_LAT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS:0]    err_count,
  output logic [ADDR_BITS-1:0]  first_fail_addr
);
  import mem_bist_pkg::*;

`ifdef MEM_BIST_INV_PASS_EN
  localparam bist_state_e FirstPassEnd = StWriteInv;
`else
  localparam bist_state_e FirstPassEnd = StDone;
`endif
  localparam logic [ADDR_BITS-1:0] LastAddr = {ADDR_BITS{1'b1}};
  localparam bit RegRead = (RD_LAT == RdLatReg);

  bist_state_e           state_q;
  logic [ADDR_BITS-1:0]  cnt_q;
  logic [ADDR_BITS-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;
  logic                  mem_wen_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_exp_q;
  logic                  accept;
  logic                  inv;
  logic [DATA_WIDTH-1:0] pat_cur;

  assign accept  = start && ((state_q == StIdle) || (state_q == StDone));
  assign inv     = (state_q == StWriteInv) || (state_q == StReadInv);
  assign pat_cur = DATA_WIDTH'(pat(32'(cnt_q), 32'(OFFSET), inv));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_exp_q   <= '0;
    end else begin
      mem_wen_q  <= 1'b0;
      mem_din_q  <= '0;
      mem_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          if (accept) begin
            state_q <= StWrite;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StWrite, StWriteInv: begin
          mem_wen_q  <= 1'b1;
          mem_addr_q <= cnt_q;
          mem_din_q  <= pat_cur;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            cnt_q   <= '0;
            state_q <= (state_q == StWrite) ? StRead : StReadInv;
          end
        end
        StRead, StReadInv: begin
          mem_addr_q <= cnt_q;
          rd_vld_q   <= 1'b1;
          rd_exp_q   <= pat_cur;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            cnt_q <= '0;
            if (state_q == StRead) state_q <= RegRead ? StDrain : FirstPassEnd;
            else                   state_q <= RegRead ? StDrainInv : StDone;
          end
        end
        StDrain:    state_q <= FirstPassEnd;
        StDrainInv: state_q <= StDone;
        default:    state_q <= StIdle;
      endcase
    end
  end

  // The compare stage sees the address/expectation registered alongside mem_addr.
  bist_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS),
    .RD_LAT    (RD_LAT)
  ) u_cmp (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (accept),
    .vld_i            (rd_vld_q),
    .addr_i           (mem_addr_q),
    .exp_i            (rd_exp_q),
    .dout_i           (mem_dout),
    .err_count_o      (err_count),
    .first_fail_addr_o(first_fail_addr)
  );

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_wen  = mem_wen_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q && (err_count == '0);

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Self-contained write-then-read-back sequencer for the reg_mem register memory.
- Sweeps every address with a deterministic pattern, reads each location back, compares it against the expected value, and reports the result.
- Replaces hand-written testbench loops with synthesizable logic.
- Sits directly on reg_mem's addr/data_in/wen/data_out pins; data_out is the responder side and this block is the initiator.

Parameters:
- DATA_WIDTH, 8, width of the memory data word.
- ADDR_BITS, 5, memory address width; depth N = 2**ADDR_BITS.
- OFFSET, 0, pattern offset: expected data = (addr + OFFSET) mod 2**DATA_WIDTH.
- RD_LAT, 0, memory read latency in cycles; legal values are 0 (combinational data_out) or 1 (registered data_out).

Ports:
- clk  in  1  rising-edge clock, shared with reg_mem.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- mem_addr  out  ADDR_BITS  to reg_mem addr.
- mem_din  out  DATA_WIDTH  to reg_mem data_in.
- mem_wen  out  1  to reg_mem wen.
- mem_dout  in  DATA_WIDTH  from reg_mem data_out.
- busy  out  1  high from the accept cycle until DONE.
- done  out  1  level; high in DONE until the next accepted start or rst.
- pass  out  1  equals done AND err_count==0.
- err_count  out  ADDR_BITS+1  mismatch count; saturates at all-ones.
- first_fail_addr  out  ADDR_BITS  address of the first mismatch; 0 if none.

Behaviour:
- Reset, sampled at a clk edge, forces:
  - state=IDLE.
  - mem_addr=0, mem_din=0, mem_wen=0.
  - busy=0, done=0, err_count=0, first_fail_addr=0.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE + start: go to WRITE next cycle.
  - Clears err_count, first_fail_addr and done.
  - Sets busy.
- WRITE:
  - Drives mem_wen=1, mem_addr=a, mem_din=a+OFFSET for a = 0..N-1, one address per cycle.
  - After a=N-1, go to READ with mem_addr=0 and mem_wen=0.
  - Takes exactly N cycles.
- READ:
  - Drives mem_addr=a for a = 0..N-1, one per cycle, with mem_wen=0.
  - The expected value and address enter an RD_LAT-deep pipeline.
  - Compare mem_dout with the pipelined expected value in the cycle the data is valid (same cycle for RD_LAT=0, next cycle for RD_LAT=1).
  - After a=N-1: go to DRAIN if RD_LAT=1, else directly to DONE.
- DRAIN: one cycle to perform the last compare, then DONE.
- Mismatch:
  - err_count increments, saturating.
  - If this is the first mismatch of the run, first_fail_addr captures the pipelined address.
- DONE: busy=0, done=1; outputs hold until start or rst.
- Latency from the accepted-start edge to done=1: 2N+RD_LAT+1 cycles (for N=32, RD_LAT=0: 65).
- start while busy is ignored; the sequence is not restarted.
- rst mid-sequence takes effect at that edge:
  - mem_wen drops in the same cycle.
  - Partial memory contents are undefined, and no result is reported.
- Address counter width is ADDR_BITS; N-1 is detected explicitly, with no reliance on wrap.
- Pattern addition is truncated to DATA_WIDTH, e.g. addr 31 + OFFSET 250 gives 25 for DW=8.
- mem_din is don't-care outside WRITE but is driven 0.

Optional Feature:
- Macro: MEM_BIST_INV_PASS_EN.
- Defined:
  - After READ/DRAIN, run WRITE_INV then READ_INV (plus DRAIN_INV if RD_LAT=1), using pattern ~(a+OFFSET).
  - The compare and error rules are unchanged, with a shared err_count and first_fail_addr.
  - Latency becomes 4N+2*RD_LAT+1.
- Undefined: the states do not exist; behaviour is exactly as above.

Decomposition:
- Package mem_bist_pkg holds:
  - The state enum (including the INV states, always declared).
  - A pattern function pat(addr, offset, inv).
  - The constant for legal RD_LAT values.
- One natural sub-module: bist_cmp_pipe. It contains:
  - The RD_LAT-deep pipeline for {valid, addr, expected}.
  - The comparator.
  - The saturating error counter and first-fail capture.

Test Plan:
- rst, then start with an ideal reg_mem model (DW=8, AB=5, OFFSET=0, RD_LAT=0). Required response:
  - Writes data 0..31 to addr 0..31.
  - done=1 exactly 65 cycles after the start edge.
  - pass=1, err_count=0.
- Model with bit 3 stuck-at-0 at addr 12:
  - Required: err_count=1, first_fail_addr=12, pass=0.
- OFFSET=250, RD_LAT=1 model, with addr 31 returning 0 instead of 25:
  - Required: err_count=1, first_fail_addr=31, done at 66 cycles.
- Model with all data bits stuck-at-0:
  - Required: err_count=31, because addr 0 holds pattern 0 and matches.
  - Required: first_fail_addr=1.
- start pulsed again at cycle 10:
  - Required: ignored, with done still at 65.
  - Then rst at cycle 20 of a new run. Required: mem_wen=0 and busy=0 next cycle, state IDLE, done=0.
- With MEM_BIST_INV_PASS_EN and an ideal model:
  - Required: writes ~a in the second sweep (addr 5 gets 8'hFA), done at 129 cycles, pass=1.
